ovi_sb_tracker: RTL and testbench

- Parametrised scoreboard-ID tracker between the SweRV core-side issue/completed buses and the OVI VPU issue/dispatch/completed buses.
- Allocates sb_ids in order and meters issue with OVI credits.
- Converts core commit/kill into dispatch pulses and matches out-of-order VPU completions back to in-order retirement on the core completed bus.
- Replaces fixed single-outstanding handshaking with DEPTH outstanding instructions.

---
 rtl/ovi_sb_tracker.sv | 175 +++++++++++++++++
 tb/tb_ovi_sb_tracker.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ovi_sb_tracker.sv
// Scoreboard-ID tracker between the core issue/completion buses and the OVI VPU buses.
// It allocates sb_ids in order, meters issue with credits, and retires out-of-order completions in order.
module ovi_sb_tracker #(
  parameter int SBID_WIDTH = 5,
  parameter int CREDITS    = 4,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  core_valid,
  input  logic                  core_wb,
  input  logic [4:0]            core_dst,
  output logic                  core_ready,
  output logic                  issue_valid,
  output logic [SBID_WIDTH-1:0] issue_sb_id,
  input  logic                  issue_credit,
  input  logic                  core_commit,
  input  logic                  core_kill,
  output logic                  disp_valid,
  output logic [SBID_WIDTH-1:0] disp_sb_id,
  output logic                  disp_next_senior,
  output logic                  disp_kill,
  input  logic                  compl_valid,
  input  logic [SBID_WIDTH-1:0] compl_sb_id,
  input  logic [DATA_WIDTH-1:0] compl_dest_reg,
  input  logic                  compl_illegal,
  output logic                  core_compl_valid,
  output logic                  core_compl_wb,
  output logic [4:0]            core_compl_dst,
  output logic [DATA_WIDTH-1:0] core_compl_data,
  output logic                  core_compl_illegal,
  output logic [SBID_WIDTH:0]   outstanding,
  output logic                  err
);

  localparam int DEPTH = 2**SBID_WIDTH;
  localparam int CW    = $clog2(CREDITS + 1);
  localparam int OW    = SBID_WIDTH + 1;

  typedef enum logic [2:0] {
    S_FREE,
    S_ISSUED,
    S_DISPATCHED,
    S_DONE,
    S_KILLED
  } entry_state_t;

  entry_state_t          state_q     [DEPTH];
  logic                  ent_wb      [DEPTH];
  logic [4:0]            ent_dst     [DEPTH];
  logic [DATA_WIDTH-1:0] ent_data    [DEPTH];
  logic                  ent_illegal [DEPTH];

  logic [SBID_WIDTH-1:0] alloc_ptr;
  logic [SBID_WIDTH-1:0] disp_ptr;
  logic [SBID_WIDTH-1:0] retire_ptr;
  logic [CW-1:0]         credit_cnt;

  logic accept;
  logic disp_req;
  logic disp_ok;
  logic compl_ok;
  logic retire_done;
  logic retire_kill;
  logic retire_any;
  logic credit_full;

  // Full versus empty is decided by the outstanding count since the pointers alias when they wrap.
  assign core_ready  = (credit_cnt != '0) && (outstanding != OW'(DEPTH));
  assign accept      = core_valid & core_ready;
  assign disp_req    = core_commit | core_kill;
  assign disp_ok     = (state_q[disp_ptr] == S_ISSUED) || (accept && (alloc_ptr == disp_ptr));
  assign compl_ok    = (state_q[compl_sb_id] == S_DISPATCHED);
  assign retire_done = (state_q[retire_ptr] == S_DONE);
  assign retire_kill = (state_q[retire_ptr] == S_KILLED);
  assign retire_any  = retire_done | retire_kill;
  assign credit_full = (credit_cnt == CW'(CREDITS));

  // Issue, dispatch, completion and retirement always touch distinct entries, except that a dispatch
  // may target the entry allocated in the same cycle; the dispatch write comes later and wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        state_q[i] <= S_FREE;
      end
      alloc_ptr          <= '0;
      disp_ptr           <= '0;
      retire_ptr         <= '0;
      credit_cnt         <= CW'(CREDITS);
      outstanding        <= '0;
      err                <= 1'b0;
      issue_valid        <= 1'b0;
      issue_sb_id        <= '0;
      disp_valid         <= 1'b0;
      disp_sb_id         <= '0;
      disp_next_senior   <= 1'b0;
      disp_kill          <= 1'b0;
      core_compl_valid   <= 1'b0;
      core_compl_wb      <= 1'b0;
      core_compl_dst     <= '0;
      core_compl_data    <= '0;
      core_compl_illegal <= 1'b0;
    end else begin
      issue_valid      <= accept;
      disp_valid       <= 1'b0;
      disp_next_senior <= 1'b0;
      disp_kill        <= 1'b0;
      core_compl_valid <= 1'b0;

      if (accept) begin
        state_q[alloc_ptr] <= S_ISSUED;
        ent_wb[alloc_ptr]  <= core_wb;
        ent_dst[alloc_ptr] <= core_dst;
        issue_sb_id        <= alloc_ptr;
        alloc_ptr          <= alloc_ptr + SBID_WIDTH'(1);
      end

      if (disp_req) begin
        if (disp_ok) begin
          disp_valid        <= 1'b1;
          disp_sb_id        <= disp_ptr;
          disp_next_senior  <= ~core_kill;
          disp_kill         <= core_kill;
          state_q[disp_ptr] <= core_kill ? S_KILLED : S_DISPATCHED;
          disp_ptr          <= disp_ptr + SBID_WIDTH'(1);
        end
        if (!disp_ok || (core_commit && core_kill)) begin
          err <= 1'b1;
        end
      end

      if (compl_valid) begin
        if (compl_ok) begin
          state_q[compl_sb_id]     <= S_DONE;
          ent_data[compl_sb_id]    <= compl_dest_reg;
          ent_illegal[compl_sb_id] <= compl_illegal;
        end else begin
          err <= 1'b1;
        end
      end

      if (retire_done) begin
        core_compl_valid    <= 1'b1;
        core_compl_wb       <= ent_wb[retire_ptr];
        core_compl_dst      <= ent_dst[retire_ptr];
        core_compl_data     <= ent_data[retire_ptr];
        core_compl_illegal  <= ent_illegal[retire_ptr];
        state_q[retire_ptr] <= S_FREE;
        retire_ptr          <= retire_ptr + SBID_WIDTH'(1);
      end else if (retire_kill) begin
        state_q[retire_ptr] <= S_FREE;
        retire_ptr          <= retire_ptr + SBID_WIDTH'(1);
      end

      case ({accept, issue_credit})
        2'b10: credit_cnt <= credit_cnt - CW'(1);
        2'b01: begin
          if (credit_full) begin
            err <= 1'b1;
          end else begin
            credit_cnt <= credit_cnt + CW'(1);
          end
        end
        default: ;
      endcase

      case ({accept, retire_any})
        2'b10:   outstanding <= outstanding + OW'(1);
        2'b01:   outstanding <= outstanding - OW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ovi_sb_tracker.sv
// Directed bench for ovi_sb_tracker with a small table so wrap-around and the full condition are reachable.
// Expected issue, dispatch and retirement records are queued as stimulus is applied and popped by a monitor.
module tb_ovi_sb_tracker;

  localparam int SW = 2;
  localparam int CR = 4;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          core_valid;
  logic          core_wb;
  logic [4:0]    core_dst;
  logic          core_ready;
  logic          issue_valid;
  logic [SW-1:0] issue_sb_id;
  logic          issue_credit;
  logic          core_commit;
  logic          core_kill;
  logic          disp_valid;
  logic [SW-1:0] disp_sb_id;
  logic          disp_next_senior;
  logic          disp_kill;
  logic          compl_valid;
  logic [SW-1:0] compl_sb_id;
  logic [DW-1:0] compl_dest_reg;
  logic          compl_illegal;
  logic          core_compl_valid;
  logic          core_compl_wb;
  logic [4:0]    core_compl_dst;
  logic [DW-1:0] core_compl_data;
  logic          core_compl_illegal;
  logic [SW:0]   outstanding;
  logic          err;

  int checks = 0;
  int failures = 0;
  int retire_count = 0;

  logic [SW-1:0] issue_q [$];
  logic [SW+1:0] disp_q  [$];
  logic [70:0]   ret_q   [$];

  always #5 clk = ~clk;

  ovi_sb_tracker #(
    .SBID_WIDTH(SW),
    .CREDITS(CR),
    .DATA_WIDTH(DW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .core_valid(core_valid),
    .core_wb(core_wb),
    .core_dst(core_dst),
    .core_ready(core_ready),
    .issue_valid(issue_valid),
    .issue_sb_id(issue_sb_id),
    .issue_credit(issue_credit),
    .core_commit(core_commit),
    .core_kill(core_kill),
    .disp_valid(disp_valid),
    .disp_sb_id(disp_sb_id),
    .disp_next_senior(disp_next_senior),
    .disp_kill(disp_kill),
    .compl_valid(compl_valid),
    .compl_sb_id(compl_sb_id),
    .compl_dest_reg(compl_dest_reg),
    .compl_illegal(compl_illegal),
    .core_compl_valid(core_compl_valid),
    .core_compl_wb(core_compl_wb),
    .core_compl_dst(core_compl_dst),
    .core_compl_data(core_compl_data),
    .core_compl_illegal(core_compl_illegal),
    .outstanding(outstanding),
    .err(err)
  );

  task automatic check_output(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [70:0] rec(input logic wb, input logic [4:0] dst, input logic [63:0] data,
                                      input logic ill);
    return {wb, dst, data, ill};
  endfunction

  always @(negedge clk) begin
    if (issue_valid === 1'b1) begin
      if (issue_q.size() == 0) check_output("issue_unexpected", issue_valid, 1'b0);
      else check_output("issue_sb_id", issue_sb_id, issue_q.pop_front());
    end
    if (disp_valid === 1'b1) begin
      if (disp_q.size() == 0) check_output("disp_unexpected", disp_valid, 1'b0);
      else check_output("disp_record", {disp_sb_id, disp_next_senior, disp_kill}, disp_q.pop_front());
    end
    if (core_compl_valid === 1'b1) begin
      retire_count++;
      if (ret_q.size() == 0) check_output("retire_unexpected", core_compl_valid, 1'b0);
      else check_output("retire_record",
                        {core_compl_wb, core_compl_dst, core_compl_data, core_compl_illegal},
                        ret_q.pop_front());
    end
  end

  task automatic clear_inputs();
    core_valid = 0; core_wb = 0; core_dst = '0; issue_credit = 0; core_commit = 0; core_kill = 0;
    compl_valid = 0; compl_sb_id = '0; compl_dest_reg = '0; compl_illegal = 0;
  endtask

  // One clock of stimulus, starting and ending just after a rising edge.
  task automatic apply_stimulus(input logic v, input logic wb, input logic [4:0] dst, input logic credit,
                                input logic commit, input logic kill, input logic cv,
                                input logic [SW-1:0] cid, input logic [DW-1:0] cdata, input logic cill);
    core_valid = v; core_wb = wb; core_dst = dst; issue_credit = credit;
    core_commit = commit; core_kill = kill;
    compl_valid = cv; compl_sb_id = cid; compl_dest_reg = cdata; compl_illegal = cill;
    @(posedge clk);
    #1;
    clear_inputs();
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_issue(input logic wb, input logic [4:0] dst, input logic commit, input logic exp_ready,
                          input logic [SW-1:0] exp_sb);
    check_output("core_ready", core_ready, exp_ready);
    if (exp_ready) begin
      issue_q.push_back(exp_sb);
      if (commit) disp_q.push_back({exp_sb, 1'b1, 1'b0});
    end
    apply_stimulus(1'b1, wb, dst, 1'b0, commit, 1'b0, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic do_commit(input logic [SW-1:0] exp_sb, input logic kill, input logic credit);
    disp_q.push_back({exp_sb, ~kill, kill});
    apply_stimulus(1'b0, 1'b0, '0, credit, ~kill, kill, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic do_complete(input logic [SW-1:0] sb, input logic [DW-1:0] data, input logic ill,
                             input logic credit);
    apply_stimulus(1'b0, 1'b0, '0, credit, 1'b0, 1'b0, 1'b1, sb, data, ill);
  endtask

  task automatic check_reset_state(input string tag);
    check_output(tag, {core_ready, issue_valid, issue_sb_id, disp_valid, disp_sb_id, disp_next_senior,
                       disp_kill, core_compl_valid, core_compl_wb, core_compl_dst, core_compl_illegal,
                       outstanding, err}, {1'b1, 20'b0});
    check_output({tag, "_data"}, core_compl_data, 64'd0);
  endtask

  // Inputs are held active during reset to show they are ignored.
  task automatic do_reset();
    rst = 1; core_valid = 1; core_commit = 1; issue_credit = 1; compl_valid = 1;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    clear_inputs();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    check_reset_state("reset_state");

    // Single instruction end to end.
    do_issue(1'b1, 5'd7, 1'b0, 1'b1, 2'd0);
    check_output("t1_issue_pulse", issue_valid, 1'b1);
    do_commit(2'd0, 1'b0, 1'b0);
    check_output("t1_issue_one_cycle", issue_valid, 1'b0);
    ret_q.push_back(rec(1'b1, 5'd7, 64'hDEAD, 1'b0));
    do_complete(2'd0, 64'hDEAD, 1'b0, 1'b1);
    idle(2);
    check_output("t1_outstanding", outstanding, 3'd0);
    check_output("t1_retired", retire_count, 1);

    // Credits and the full table.
    do_issue(1'b0, 5'd3, 1'b0, 1'b1, 2'd1);
    do_issue(1'b1, 5'd4, 1'b0, 1'b1, 2'd2);
    do_issue(1'b1, 5'd5, 1'b0, 1'b1, 2'd3);
    do_issue(1'b0, 5'd6, 1'b0, 1'b1, 2'd0);
    do_issue(1'b1, 5'd9, 1'b0, 1'b0, 2'd0);
    check_output("t2_outstanding_full", outstanding, 3'd4);
    apply_stimulus(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    check_output("t2_full_with_credit", core_ready, 1'b0);
    do_commit(2'd1, 1'b0, 1'b0);
    ret_q.push_back(rec(1'b0, 5'd3, 64'h11, 1'b0));
    do_complete(2'd1, 64'h11, 1'b0, 1'b0);
    idle(2);
    check_output("t2_ready_after_retire", core_ready, 1'b1);
    do_issue(1'b1, 5'd8, 1'b0, 1'b1, 2'd1);
    check_output("t2_no_credit", core_ready, 1'b0);
    do_commit(2'd2, 1'b0, 1'b0);
    ret_q.push_back(rec(1'b1, 5'd4, 64'h22, 1'b0));
    do_complete(2'd2, 64'h22, 1'b0, 1'b0);
    idle(2);
    check_output("t2_credit_limited", core_ready, 1'b0);
    check_output("t2_outstanding", outstanding, 3'd3);

    // Out-of-order completion, in-order retirement (oldest sb3, then sb0, then sb1).
    do_commit(2'd3, 1'b0, 1'b1);
    do_commit(2'd0, 1'b0, 1'b1);
    do_commit(2'd1, 1'b0, 1'b1);
    ret_q.push_back(rec(1'b1, 5'd5, 64'h33, 1'b0));
    ret_q.push_back(rec(1'b0, 5'd6, 64'h44, 1'b1));
    ret_q.push_back(rec(1'b1, 5'd8, 64'h55, 1'b0));
    do_complete(2'd1, 64'h55, 1'b0, 1'b1);
    idle(3);
    check_output("t3_hold_youngest", retire_count, 3);
    do_complete(2'd3, 64'h33, 1'b0, 1'b0);
    idle(3);
    check_output("t3_oldest_only", retire_count, 4);
    do_complete(2'd0, 64'h44, 1'b1, 1'b0);
    idle(3);
    check_output("t3_all_retired", retire_count, 6);
    check_output("t3_outstanding", outstanding, 3'd0);

    // Kill the older of two, commit the younger.
    do_issue(1'b1, 5'd11, 1'b0, 1'b1, 2'd2);
    do_issue(1'b1, 5'd10, 1'b0, 1'b1, 2'd3);
    do_commit(2'd2, 1'b1, 1'b0);
    do_commit(2'd3, 1'b0, 1'b0);
    ret_q.push_back(rec(1'b1, 5'd10, 64'h77, 1'b0));
    do_complete(2'd3, 64'h77, 1'b0, 1'b1);
    apply_stimulus(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    idle(3);
    check_output("t4_one_retire", retire_count, 7);
    check_output("t4_outstanding", outstanding, 3'd0);
    check_output("t4_no_err", err, 1'b0);

    // Nine instructions through the four-entry table, committed in the issue cycle.
    for (int i = 0; i < 9; i++) begin
      ret_q.push_back(rec(1'b1, 5'(i), 64'(256 + i), 1'b0));
      do_issue(1'b1, 5'(i), 1'b1, 1'b1, 2'(i));
      do_complete(2'(i), 64'(256 + i), 1'b0, 1'b1);
    end
    idle(3);
    check_output("t5_retired", retire_count, 16);
    check_output("t5_outstanding", outstanding, 3'd0);
    check_output("t5_no_err", err, 1'b0);

    // Commit with nothing issued.
    apply_stimulus(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
    check_output("e1_err", err, 1'b1);
    idle(2);
    check_output("e1_err_sticky", err, 1'b1);
    do_reset();
    check_reset_state("e1_reset");

    // Completion for an undispatched entry, then reset with it in flight.
    do_issue(1'b1, 5'd2, 1'b0, 1'b1, 2'd0);
    do_complete(2'd0, 64'h99, 1'b0, 1'b0);
    check_output("e2_err", err, 1'b1);
    idle(2);
    check_output("e2_err_sticky", err, 1'b1);
    check_output("e2_outstanding", outstanding, 3'd1);
    do_reset();
    check_reset_state("e2_reset");

    // Extra credit on a full counter: only an error if reset restored the count.
    apply_stimulus(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    check_output("e3_err", err, 1'b1);
    idle(2);
    check_output("e3_err_sticky", err, 1'b1);
    do_reset();
    check_reset_state("e3_reset");

    // Commit and kill together: kill wins.
    do_issue(1'b0, 5'd1, 1'b0, 1'b1, 2'd0);
    disp_q.push_back({2'd0, 1'b0, 1'b1});
    apply_stimulus(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0, '0, '0, 1'b0);
    check_output("e4_err", err, 1'b1);
    idle(3);
    check_output("e4_killed_freed", outstanding, 3'd0);
    do_reset();
    check_reset_state("e4_reset");

    check_output("issue_q_drained", issue_q.size(), 0);
    check_output("disp_q_drained", disp_q.size(), 0);
    check_output("ret_q_drained", ret_q.size(), 0);
    check_output("retire_total", retire_count, 16);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
